seven_seg_readback: RTL and testbench
=====================================

// Module: seven_seg_readback
// PURPOSE
//  Display-side readback monitor: the inverse of the hex-to-7-seg decoder. It
//  snoops the multiplexed, active-low segment/anode bus that drives the vending
//  front-panel display and waits for each strobed digit to become stable.
//  It then converts the segment pattern back to a hex nibble, so that control
//  logic and self-test can confirm what the customer actually sees.
// PARAMETERS
//  NUM_DIGITS     4   number of multiplexed digits (anode lines)
//  STABLE_CYCLES  8   consecutive identical samples required before capture (>=2)
//  CNT_W          $clog2(STABLE_CYCLES+1)  stability counter width (derived, localparam)
// PORTS
//  clk          in   1             system clock
//  rst_n        in   1             synchronous reset, active-low
//  seg          in   7             segment bus {g,f,e,d,c,b,a}, active-low (1 = off)
//  an           in   NUM_DIGITS    anode strobes, active-low, one-hot-low expected
//  clr          in   1             synchronous clear of digit_valid, digit_bad, ghost_err
//  digits       out  4*NUM_DIGITS  recovered nibbles, digit i at [4i+3:4i]
//  digit_valid  out  NUM_DIGITS    digit i captured since reset/clr and last capture was legal
//  digit_bad    out  NUM_DIGITS    last capture of digit i was not one of the 16 hex glyphs
//  upd          out  1             1-cycle pulse: a capture was written this cycle
//  upd_idx      out  $clog2(NUM_DIGITS)  digit index of the capture flagged by upd
//  frame_done   out  1             1-cycle pulse: every digit captured since the last frame_done
//  ghost_err    out  1             sticky: more than one anode was seen low at once
// BEHAVIOUR
//  - Clock and reset: one clock domain. rst_n is sampled on the clk edge.
//    Reset gives: digits=0, digit_valid=0, digit_bad=0, upd=0, upd_idx=0,
//    frame_done=0, ghost_err=0. It also gives state=IDLE, count=0, frame mask=0
//    and input registers = all-ones (blank).
//  - Input stage: seg and an are registered once. All decisions use the
//    registered copy (seg_q, an_q) plus the previous sample (seg_p, an_p).
//  - Sample classification: exactly one bit of an_q is 0 -> "single". All ones
//    -> "blank". Two or more zeros -> "ghost".
//  - State IDLE: wait for a single sample -> COUNT, with count=1.
//  - State COUNT:
//    * Single sample with (seg_q,an_q)==(seg_p,an_p): count++.
//    * Single sample with a different pair: count=1 and stay in COUNT.
//    * Blank sample -> IDLE.
//    * Ghost sample -> IDLE and set ghost_err.
//    * On the edge where count would reach STABLE_CYCLES: capture -> HOLD.
//  - Capture: idx = position of the low anode bit. The seg_q pattern goes
//    through the inverse LUT. On a match: digits[idx]=nibble,
//    digit_valid[idx]=1, digit_bad[idx]=0. On no match: digits[idx] unchanged,
//    digit_valid[idx]=0, digit_bad[idx]=1. In both cases upd=1, upd_idx=idx for
//    exactly that cycle, and idx is set in the frame mask.
//  - Latency: a pair held on the pins from cycle 0 gives upd high in cycle
//    STABLE_CYCLES+1. There is no capture if the pair is held for fewer than
//    STABLE_CYCLES samples.
//  - State HOLD: stay while the sample equals the captured pair, so one strobe
//    gives one capture however long it lasts. Any change -> IDLE. A ghost
//    sample also sets ghost_err. A different single anode goes straight to
//    COUNT with count=1.
//  - frame_done: asserted in the same cycle as the upd that completes the mask.
//    The mask is then cleared to 0; the completing digit is not carried over.
//    A repeat capture of a digit already in the mask does not pulse frame_done.
//  - clr: clears digit_valid, digit_bad, ghost_err and the frame mask. If clr
//    coincides with a capture, the capture wins for that digit's valid/bad
//    bits and for its mask bit. digits is never cleared by clr.
//  - Reset mid-operation: state returns to IDLE and any partial count is
//    discarded. rst_n takes priority over clr and capture.
//  - Inverse LUT (active-low {g..a} -> nibble). Any other pattern is bad.
//    0:40 1:79 2:24 3:30 4:19 5:12 6:02 7:78
//    8:00 9:10 A:08 b:03 C:46 d:21 E:06 F:0E
// STRUCTURE
//  - seven_seg_pkg:
//    * SEG_GLYPH[16] localparam table (the values above)
//    * typedef seg_t = logic [6:0]
//    * enum rb_state_t {IDLE, COUNT, HOLD}
//  - Sub-module seg_to_hex: purely combinational. seg_t in ->
//    {logic hit, logic [3:0] nib} out. Built as a 16-way compare against
//    SEG_GLYPH. It is also reused by the test bench as a checker.
//  - Top level: input registers, classifier, FSM plus counter, one-hot-to-index
//    encoder, digit/flag registers, frame mask.
// TESTING
//  1. an=4'b1110, seg=7'h30 held 12 cycles -> upd in cycle 9, upd_idx=0,
//     digits[3:0]=4'h3, digit_valid=4'b0001, and only one upd.
//  2. Scan an=1110,1101,1011,0111 with seg=02,78,46,0E, 10 cycles each ->
//     digits=16'hFC76, digit_valid=4'hF, frame_done pulses with the 4th upd only.
//  3. an=4'b1101, seg=7'h7F (blank glyph) held 10 cycles -> digit_bad[1]=1,
//     digit_valid[1]=0, digits[7:4] unchanged, upd pulses once.
//  4. an=4'b1110, seg=7'h24 for 5 cycles, then seg=7'h30 for 10 cycles -> no
//     capture of 2; one capture of 3, in the 9th cycle after the change.
//  5. an=4'b1100 for 1 cycle during a COUNT -> ghost_err=1 and stays 1. No upd
//     from the interrupted digit. clr for 1 cycle -> ghost_err=0, digit_valid=0.
//  6. rst_n=0 for 1 cycle at count=6 of a stable digit, then the same input held
//     -> all outputs at reset values; capture occurs STABLE_CYCLES+1 cycles
//     after rst_n returns to 1.

Source files
------------

// File: rtl/seven_seg_readback_pkg.sv
// seven_seg_readback_pkg: shared types and the glyph table for segment readback
package seven_seg_readback_pkg;

    typedef logic [6:0] seg_t;

    typedef enum logic [1:0] {IDLE, COUNT, HOLD} rb_state_t;

    // Active-low {g,f,e,d,c,b,a} patterns for nibbles 0..F
    localparam seg_t SEG_GLYPH [16] = '{
        7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
        7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E
    };

endpackage

// File: rtl/seven_seg_readback_seg_to_hex.sv
// seg_to_hex: combinational inverse of the hex-to-7-seg decoder
module seg_to_hex
    import seven_seg_readback_pkg::*;
(
    input  seg_t       seg_i,
    output logic       hit_o,
    output logic [3:0] nib_o
);

    // 16-way compare against the glyph table; no match leaves hit_o low
    always_comb begin
        hit_o = 1'b0;
        nib_o = 4'h0;
        for (int i = 0; i < 16; i++) begin
            if (seg_i == SEG_GLYPH[i]) begin
                hit_o = 1'b1;
                nib_o = 4'(i);
            end
        end
    end

endmodule

// File: rtl/seven_seg_readback.sv
// seven_seg_readback: recovers hex digits from a multiplexed active-low 7-seg bus
module seven_seg_readback
    import seven_seg_readback_pkg::*;
#(
    parameter int NUM_DIGITS    = 4,
    parameter int STABLE_CYCLES = 8
) (
    input  logic                                       clk_i,
    input  logic                                       rst_ni,
    input  seg_t                                       seg_i,
    input  logic [NUM_DIGITS-1:0]                      an_i,
    input  logic                                       clr_i,
    output logic [4*NUM_DIGITS-1:0]                    digits_o,
    output logic [NUM_DIGITS-1:0]                      digit_valid_o,
    output logic [NUM_DIGITS-1:0]                      digit_bad_o,
    output logic                                       upd_o,
    output logic [(NUM_DIGITS>1 ? $clog2(NUM_DIGITS) : 1)-1:0] upd_idx_o,
    output logic                                       frame_done_o,
    output logic                                       ghost_err_o
);

    localparam int CNT_W = $clog2(STABLE_CYCLES + 1);
    localparam int IDX_W = NUM_DIGITS > 1 ? $clog2(NUM_DIGITS) : 1;

    seg_t                    seg_q, seg_p;
    logic [NUM_DIGITS-1:0]   an_q, an_p;
    rb_state_t               state_q;
    logic [CNT_W-1:0]        cnt_q;
    logic [NUM_DIGITS-1:0]   mask_q, mask_d;
    logic [4*NUM_DIGITS-1:0] digits_q, digits_d;
    logic [NUM_DIGITS-1:0]   valid_q, valid_d, bad_q, bad_d;
    logic                    upd_q, frame_q, frame_d, ghost_q;
    logic [IDX_W-1:0]        idx_q, idx;
    logic                    single, blank, ghost, same, cap, ghost_set, hit;
    logic [3:0]              nib;

    assign single    = $onehot(~an_q);
    assign blank     = &an_q;
    assign ghost     = !single && !blank;
    assign same      = (seg_q == seg_p) && (an_q == an_p);
    assign cap       = (state_q == COUNT) && single && same && (cnt_q == CNT_W'(STABLE_CYCLES - 1));
    assign ghost_set = (state_q != IDLE) && ghost;

    seg_to_hex u_lut (.seg_i(seg_q), .hit_o(hit), .nib_o(nib));

    // Register the bus once and keep the previous sample for stability compares
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            seg_q <= '1;
            an_q  <= '1;
            seg_p <= '1;
            an_p  <= '1;
        end else begin
            seg_q <= seg_i;
            an_q  <= an_i;
            seg_p <= seg_q;
            an_p  <= an_q;
        end
    end

    // Position of the low anode bit (meaningful only for a single sample)
    always_comb begin
        idx = '0;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            if (!an_q[i]) idx = IDX_W'(i);
        end
    end

    // Stability FSM: count identical single samples, capture once, hold until change
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            state_q <= IDLE;
            cnt_q   <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (single) begin
                        state_q <= COUNT;
                        cnt_q   <= CNT_W'(1);
                    end
                end
                COUNT: begin
                    if (!single) state_q <= IDLE;
                    else if (!same) cnt_q <= CNT_W'(1);
                    else begin
                        cnt_q <= cnt_q + 1'b1;
                        if (cap) state_q <= HOLD;
                    end
                end
                HOLD: begin
                    if (!same) begin
                        state_q <= single ? COUNT : IDLE;
                        cnt_q   <= CNT_W'(1);
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    // Next values of digit flags and frame mask; a capture overrides a coincident clr
    always_comb begin
        valid_d  = clr_i ? '0 : valid_q;
        bad_d    = clr_i ? '0 : bad_q;
        mask_d   = clr_i ? '0 : mask_q;
        digits_d = digits_q;
        if (cap) begin
            valid_d[idx] = hit;
            bad_d[idx]   = !hit;
            mask_d[idx]  = 1'b1;
            if (hit) digits_d[{idx, 2'b00} +: 4] = nib;
        end
        frame_d = cap && (&mask_d);
        if (frame_d) mask_d = '0;
    end

    // Output and flag registers
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            digits_q <= '0;
            valid_q  <= '0;
            bad_q    <= '0;
            mask_q   <= '0;
            upd_q    <= 1'b0;
            idx_q    <= '0;
            frame_q  <= 1'b0;
            ghost_q  <= 1'b0;
        end else begin
            digits_q <= digits_d;
            valid_q  <= valid_d;
            bad_q    <= bad_d;
            mask_q   <= mask_d;
            upd_q    <= cap;
            idx_q    <= cap ? idx : idx_q;
            frame_q  <= frame_d;
            ghost_q  <= (ghost_q && !clr_i) || ghost_set;
        end
    end

    assign digits_o      = digits_q;
    assign digit_valid_o = valid_q;
    assign digit_bad_o   = bad_q;
    assign upd_o         = upd_q;
    assign upd_idx_o     = idx_q;
    assign frame_done_o  = frame_q;
    assign ghost_err_o   = ghost_q;

endmodule

// File: tb/tb_seven_seg_readback.sv
// tb_seven_seg_readback: directed tables plus random bus traffic against a run-length model
module tb_seven_seg_readback;

    localparam int ND = 4;
    localparam int SC = 8;

    logic        clk, rst_n, clr;
    logic [6:0]  seg;
    logic [3:0]  an;
    logic [15:0] digits;
    logic [3:0]  digit_valid, digit_bad;
    logic        upd, frame_done, ghost_err;
    logic [1:0]  upd_idx;

    int checks = 0;
    int errors = 0;

    seven_seg_readback #(.NUM_DIGITS(ND), .STABLE_CYCLES(SC)) dut (
        .clk_i(clk), .rst_ni(rst_n), .seg_i(seg), .an_i(an), .clr_i(clr),
        .digits_o(digits), .digit_valid_o(digit_valid), .digit_bad_o(digit_bad),
        .upd_o(upd), .upd_idx_o(upd_idx), .frame_done_o(frame_done), .ghost_err_o(ghost_err)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    logic [6:0] glyph [16] = '{
        7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
        7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E
    };

    // Reference model: the registered sample stream, the length of the current
    // run of identical single-anode samples, and the expected outputs.
    logic [6:0]  m_seg, m_pseg;
    logic [3:0]  m_an, m_pan;
    int          m_run;
    logic [15:0] m_digits;
    logic [3:0]  m_valid, m_bad, m_mask;
    logic        m_upd, m_fd, m_ghost;
    logic [1:0]  m_idx;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_step();
        int zeros, k;
        bit found;
        if (!rst_n) begin
            m_seg = 7'h7F; m_pseg = 7'h7F; m_an = 4'hF; m_pan = 4'hF; m_run = 0;
            m_digits = '0; m_valid = '0; m_bad = '0; m_mask = '0;
            m_upd = 0; m_fd = 0; m_ghost = 0; m_idx = '0;
            return;
        end
        m_upd = 0;
        m_fd  = 0;
        if (clr) begin
            m_valid = '0; m_bad = '0; m_ghost = 0; m_mask = '0;
        end
        zeros = $countones(~m_an);
        if (zeros > 1) begin
            if (m_run > 0) m_ghost = 1;
            m_run = 0;
        end else if (zeros == 0) begin
            m_run = 0;
        end else begin
            m_run = (m_run > 0 && m_an == m_pan && m_seg == m_pseg) ? m_run + 1 : 1;
            if (m_run == SC) begin
                k = 0;
                for (int i = 0; i < ND; i++) if (!m_an[i]) k = i;
                found = 0;
                for (int g = 0; g < 16; g++) begin
                    if (glyph[g] == m_seg) begin
                        found = 1;
                        m_digits[4*k +: 4] = 4'(g);
                    end
                end
                m_valid[k] = found;
                m_bad[k]   = !found;
                m_upd = 1;
                m_idx = 2'(k);
                m_mask[k] = 1'b1;
                if (m_mask == 4'hF) begin
                    m_fd = 1;
                    m_mask = '0;
                end
            end
        end
        m_pseg = m_seg; m_pan = m_an;
        m_seg = seg;    m_an = an;
    endtask

    task automatic tick();
        @(posedge clk);
        model_step();
        #1;
        check("digits", 32'(digits), 32'(m_digits));
        check("digit_valid", 32'(digit_valid), 32'(m_valid));
        check("digit_bad", 32'(digit_bad), 32'(m_bad));
        check("upd", 32'(upd), 32'(m_upd));
        check("upd_idx", 32'(upd_idx), 32'(m_idx));
        check("frame_done", 32'(frame_done), 32'(m_fd));
        check("ghost_err", 32'(ghost_err), 32'(m_ghost));
    endtask

    task automatic hold(input logic [3:0] a, input logic [6:0] s, input int n,
                        output int nupd, output int nfd, output int first);
        an = a; seg = s;
        nupd = 0; nfd = 0; first = 0;
        for (int c = 1; c <= n; c++) begin
            tick();
            if (upd === 1'b1) begin
                nupd++;
                if (first == 0) first = c;
            end
            if (frame_done === 1'b1) nfd++;
        end
    endtask

    typedef struct {
        logic [3:0]  an;
        logic [6:0]  seg;
        int          n;
        int          exp_upd;
        int          exp_fd;
        logic [15:0] exp_digits;
        logic [3:0]  exp_valid;
        logic [3:0]  exp_bad;
    } vec_t;

    vec_t vecs [6];

    initial begin
        int nu, nf, fc;
        bit prev_single;
        logic [3:0] ra;
        logic [6:0] rs;
        int rn, r;

        vecs[0] = '{4'b1110, 7'h02, 10, 1, 0, 16'h0006, 4'b0001, 4'b0000};
        vecs[1] = '{4'b1101, 7'h78, 10, 1, 0, 16'h0076, 4'b0011, 4'b0000};
        vecs[2] = '{4'b1011, 7'h46, 10, 1, 0, 16'h0C76, 4'b0111, 4'b0000};
        vecs[3] = '{4'b0111, 7'h0E, 10, 1, 1, 16'hFC76, 4'b1111, 4'b0000};
        vecs[4] = '{4'b1101, 7'h7F, 10, 1, 0, 16'hFC76, 4'b1101, 4'b0010};
        vecs[5] = '{4'b1101, 7'h79, 10, 1, 0, 16'hFC16, 4'b1111, 4'b0000};

        rst_n = 0; clr = 0; an = 4'hF; seg = 7'h7F;
        tick();
        tick();
        rst_n = 1;
        check("reset_digits", 32'(digits), 0);
        check("reset_valid", 32'(digit_valid), 0);
        check("reset_ghost", 32'(ghost_err), 0);

        // Single held digit: one capture in cycle 9
        hold(4'b1110, 7'h30, 12, nu, nf, fc);
        check("t1_nupd", nu, 1);
        check("t1_cycle", fc, 9);
        check("t1_digit", 32'(digits[3:0]), 3);
        check("t1_valid", 32'(digit_valid), 1);
        hold(4'hF, 7'h7F, 3, nu, nf, fc);

        // Fresh frame, then scan table incl. a bad glyph and its recovery
        clr = 1; tick(); clr = 0;
        for (int i = 0; i < 6; i++) begin
            hold(vecs[i].an, vecs[i].seg, vecs[i].n, nu, nf, fc);
            check($sformatf("v%0d_nupd", i), nu, vecs[i].exp_upd);
            check($sformatf("v%0d_nfd", i), nf, vecs[i].exp_fd);
            check($sformatf("v%0d_digits", i), 32'(digits), 32'(vecs[i].exp_digits));
            check($sformatf("v%0d_valid", i), 32'(digit_valid), 32'(vecs[i].exp_valid));
            check($sformatf("v%0d_bad", i), 32'(digit_bad), 32'(vecs[i].exp_bad));
        end

        // Short run of one glyph then a change: only the second is captured
        hold(4'hF, 7'h7F, 3, nu, nf, fc);
        hold(4'b1110, 7'h24, 5, nu, nf, fc);
        check("t4_short_nupd", nu, 0);
        hold(4'b1110, 7'h30, 10, nu, nf, fc);
        check("t4_nupd", nu, 1);
        check("t4_cycle", fc, 9);
        check("t4_digit", 32'(digits[3:0]), 3);

        // Ghost interrupts a count: sticky error, no capture; clr wipes it
        hold(4'hF, 7'h7F, 3, nu, nf, fc);
        hold(4'b1011, 7'h46, 4, nu, nf, fc);
        check("t5_pre_nupd", nu, 0);
        hold(4'b1100, 7'h46, 1, nu, nf, fc);
        hold(4'b1011, 7'h46, 6, nu, nf, fc);
        check("t5_post_nupd", nu, 0);
        hold(4'hF, 7'h7F, 5, nu, nf, fc);
        check("t5_ghost", 32'(ghost_err), 1);
        clr = 1; tick(); clr = 0;
        check("t5_clr_ghost", 32'(ghost_err), 0);
        check("t5_clr_valid", 32'(digit_valid), 0);

        // Reset at count 6: partial count discarded, capture 9 cycles later
        hold(4'b0111, 7'h12, 7, nu, nf, fc);
        check("t6_pre_nupd", nu, 0);
        rst_n = 0; tick(); rst_n = 1;
        check("t6_rst_digits", 32'(digits), 0);
        check("t6_rst_upd", 32'(upd), 0);
        hold(4'b0111, 7'h12, 12, nu, nf, fc);
        check("t6_nupd", nu, 1);
        check("t6_cycle", fc, 9);
        check("t6_digit", 32'(digits[15:12]), 5);

        // Random traffic; ghosts only ever follow a single-anode sample
        hold(4'hF, 7'h7F, 2, nu, nf, fc);
        prev_single = 0;
        for (int k = 0; k < 300; k++) begin
            r = $urandom_range(0, 99);
            if (prev_single && r < 8) begin
                ra = 4'($urandom);
                while ($countones(~ra) < 2) ra = 4'($urandom);
                rs = 7'($urandom);
                rn = 1;
                prev_single = 0;
            end else if (r < 18) begin
                ra = 4'hF;
                rs = 7'($urandom);
                rn = $urandom_range(1, 4);
                prev_single = 0;
            end else begin
                ra = ~(4'b0001 << $urandom_range(0, 3));
                rs = ($urandom_range(0, 3) != 0) ? glyph[$urandom_range(0, 15)] : 7'($urandom);
                rn = $urandom_range(1, 14);
                prev_single = 1;
            end
            an = ra; seg = rs;
            for (int c = 0; c < rn; c++) begin
                clr = ($urandom_range(0, 39) == 0);
                tick();
            end
            clr = 0;
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
